fetch_stage: RTL

- First pipeline stage. Holds the program counter and issues in-order instruction-memory reads.
- Buffers returned instruction words in a small FIFO and hands {pc, instruction} to decode_stage over the done/stall handshake.
- Accepts redirects (taken branch or jump) from decode and discards wrong-path work.

---
 rtl/fetch_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the PC, issues in-order instruction reads and
// buffers returned words in a FIFO that feeds decode over done/stall.
module fetch_stage #(
    localparam int unsigned ADDR_WIDTH        = 32,
    localparam int unsigned INSTRUCTION_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = 32'h0000_0000,
    parameter int unsigned           MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_target,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_WIDTH-1:0]        imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
    input  logic                         imem_resp_error,
    input  logic                         next_stall,
    output logic                         done_next,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
    output logic                         instruction_data_valid_out
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        pc;
        logic [INSTRUCTION_WIDTH-1:0] insn;
        logic                         insn_valid;
    } fetch_entry_t;

    fetch_entry_t           fifo_q [MAX_OUTSTANDING];
    fetch_entry_t           push_entry;
    fetch_entry_t           head;

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic                   halted_q, halted_d;

    logic                   active;
    logic                   misaligned;
    logic                   credit_ok;
    logic                   fire;
    logic                   resp_live;
    logic                   resp_keep;
    logic                   fault_push;
    logic                   push;
    logic                   pop;

    // Handshake and bookkeeping strobes; a redirect or reset masks everything.
    always_comb begin
        active     = rst && !redirect_valid;
        misaligned = (pc_q[1:0] != 2'b00);
        credit_ok  = (SUM_W'(outstanding_q) + SUM_W'(count_q)) < SUM_W'(MAX_OUTSTANDING);

        imem_req_valid = active && !halted_q && !misaligned && credit_ok;
        fire           = imem_req_valid && imem_req_ready;

        // Beats with nothing in flight are untracked leftovers and ignored.
        resp_live = imem_resp_valid && (outstanding_q != '0);
        resp_keep = resp_live && (drop_q == '0);

        // Fault entry waits until every live response ahead of it has landed.
        fault_push = active && misaligned && !halted_q && (outstanding_q == drop_q)
                     && (count_q < CNT_W'(MAX_OUTSTANDING));

        done_next = active && (count_q != '0);
        pop       = done_next && !next_stall;
        push      = active && (resp_keep || fault_push);
    end

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        halted_d      = halted_q;

        push_entry = '{pc: resp_pc_q, insn: imem_resp_data, insn_valid: !imem_resp_error};
        if (fault_push) begin
            push_entry = '{pc: pc_q, insn: '0, insn_valid: 1'b0};
        end

        if (redirect_valid) begin
            // Everything still in flight becomes wrong-path and is dropped on return.
            pc_d          = redirect_target;
            resp_pc_d     = redirect_target;
            outstanding_d = outstanding_q - CNT_W'(resp_live);
            drop_d        = outstanding_q - CNT_W'(resp_live);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            halted_d      = 1'b0;
        end else begin
            if (fire) begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
            outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(resp_live);
            if (resp_live && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
            end
            if (fault_push) begin
                halted_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            halted_q      <= halted_d;
        end
    end

    // Entry storage needs no reset: count gates whether the head is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        head                       = fifo_q[rd_ptr_q];
        imem_req_addr              = pc_q;
        program_count_valid_out    = done_next;
        program_count_out          = head.pc;
        instruction_data_out       = head.insn;
        instruction_data_valid_out = head.insn_valid;
    end

    resp_has_request: assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> (outstanding_q != '0));

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        push |-> ((count_q < CNT_W'(MAX_OUTSTANDING)) || pop));

endmodule
